// File: rtl/dmem_stage_ctrl.sv
// Memory-stage controller: issues one mem_system request per load/store,
// stalls the pipeline until completion (or timeout), registers load data and
// exposes trace taps plus saturating request/hit counters.
module dmem_stage_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_rd,
    input  logic             ex_wr,
    input  logic [15:0]      ex_addr,
    input  logic [15:0]      ex_wdata,
    input  logic             halt,
    input  logic             ms_done,
    input  logic             ms_hit,
    input  logic             ms_err,
    input  logic [15:0]      ms_rdata,
    output logic             ms_rd,
    output logic             ms_wr,
    output logic [15:0]      ms_addr,
    output logic [15:0]      ms_wdata,
    output logic             stall,
    output logic [15:0]      rdata,
    output logic             resp_valid,
    output logic             mem_read_done,
    output logic             mem_write_done,
    output logic             dcache_req,
    output logic             dcache_hit,
    output logic             err,
    output logic [CNT_W-1:0] req_count,
    output logic [CNT_W-1:0] hit_count
);

    // Timeout counter only needs to reach TIMEOUT-1.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [15:0]      addr_q;
    logic [15:0]      wdata_q;
    logic [15:0]      rdata_q;
    logic             ld_q;
    logic             st_q;
    logic             err_q;
    logic [TW-1:0]    tcnt;
    logic [CNT_W-1:0] req_q;
    logic [CNT_W-1:0] hit_q;

    logic accept;
    logic illegal;
    logic timed_out;

    // A legal access has exactly one of read/write; both set is an illegal op.
    // halt only gates new issue, never an access already in flight.
    assign accept    = ex_valid & (ex_rd ^ ex_wr) & ~halt;
    assign illegal   = ex_valid & ex_rd & ex_wr & ~halt;
    assign timed_out = (tcnt == TIMEOUT_LAST);

    assign rdata     = rdata_q;
    assign req_count = req_q;
    assign hit_count = hit_q;

    // State register; reset abandons any in-flight access without a response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and request/handshake outputs decoded from the current state.
    always_comb begin
        state_next     = state;
        ms_rd          = 1'b0;
        ms_wr          = 1'b0;
        ms_addr        = addr_q;
        ms_wdata       = wdata_q;
        stall          = 1'b0;
        resp_valid     = 1'b0;
        err            = 1'b0;
        mem_read_done  = 1'b0;
        mem_write_done = 1'b0;
        dcache_req     = 1'b0;
        dcache_hit     = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    ms_rd      = ex_rd;
                    ms_wr      = ex_wr;
                    ms_addr    = ex_addr;
                    ms_wdata   = ex_wdata;
                    dcache_req = 1'b1;
                    stall      = 1'b1;
                    state_next = WAIT;
                end else if (illegal) begin
                    stall      = 1'b1;
                    state_next = RESP;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (ms_done) begin
                    dcache_hit = ms_hit;
                    state_next = RESP;
                end else if (timed_out) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid     = 1'b1;
                err            = err_q;
                mem_read_done  = ld_q & ~err_q;
                mem_write_done = st_q & ~err_q;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture, load-data register, error flag and timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ld_q    <= 1'b0;
            st_q    <= 1'b0;
            err_q   <= 1'b0;
            tcnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= ex_addr;
                        wdata_q <= ex_wdata;
                        ld_q    <= ex_rd;
                        st_q    <= ex_wr;
                        err_q   <= 1'b0;
                        tcnt    <= '0;
                    end else if (illegal) begin
                        ld_q  <= 1'b0;
                        st_q  <= 1'b0;
                        err_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (ms_done) begin
                        err_q <= ms_err;
                        if (ld_q) begin
                            rdata_q <= ms_rdata;
                        end
                    end else if (timed_out) begin
                        err_q <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                RESP: begin
                    err_q <= 1'b0;
                    tcnt  <= '0;
                end
                default: begin
                    err_q <= 1'b0;
                    tcnt  <= '0;
                end
            endcase
        end
    end

    // Saturating count of issued requests; holds at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= '0;
        end else if (dcache_req && (req_q != {CNT_W{1'b1}})) begin
            req_q <= req_q + 1'b1;
        end
    end

    // Saturating count of completed cache hits; spurious done never reaches here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q <= '0;
        end else if (dcache_hit && (hit_q != {CNT_W{1'b1}})) begin
            hit_q <= hit_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_stage_ctrl.sv
// Testbench for dmem_stage_ctrl: a cycle-by-cycle vector table on a default
// instance, plus short sequences on a TIMEOUT=4 / CNT_W=2 instance and a
// reset-in-flight sequence.
module tb_dmem_stage_ctrl;

    // Input control bits: {ex_valid, ex_rd, ex_wr, halt, ms_done, ms_hit, ms_err}
    localparam logic [6:0] I_V    = 7'h40;
    localparam logic [6:0] I_RD   = 7'h20;
    localparam logic [6:0] I_WR   = 7'h10;
    localparam logic [6:0] I_HALT = 7'h08;
    localparam logic [6:0] I_DONE = 7'h04;
    localparam logic [6:0] I_HIT  = 7'h02;
    localparam logic [6:0] I_ERR  = 7'h01;

    // Output flag bits: {ms_rd, ms_wr, stall, dcache_req, dcache_hit,
    //                    resp_valid, err, mem_read_done, mem_write_done}
    localparam logic [8:0] F_RD  = 9'h100;
    localparam logic [8:0] F_WR  = 9'h080;
    localparam logic [8:0] F_ST  = 9'h040;
    localparam logic [8:0] F_REQ = 9'h020;
    localparam logic [8:0] F_HIT = 9'h010;
    localparam logic [8:0] F_RV  = 9'h008;
    localparam logic [8:0] F_ERR = 9'h004;
    localparam logic [8:0] F_MRD = 9'h002;
    localparam logic [8:0] F_MWD = 9'h001;

    typedef struct {
        logic [6:0]  ctl;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] msrd;
        logic [8:0]  flags;
        logic [15:0] e_addr;
        logic [15:0] e_wdata;
        logic [15:0] e_rdata;
        logic [15:0] e_req;
        logic [15:0] e_hit;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_rd, ex_wr, halt;
    logic [15:0] ex_addr, ex_wdata;
    logic        ms_done, ms_hit, ms_err;
    logic [15:0] ms_rdata;

    logic        ms_rd, ms_wr, stall, resp_valid, mem_read_done, mem_write_done;
    logic        dcache_req, dcache_hit, err;
    logic [15:0] ms_addr, ms_wdata, rdata, req_count, hit_count;

    logic        t_ms_rd, t_ms_wr, t_stall, t_resp_valid, t_mem_read_done, t_mem_write_done;
    logic        t_dcache_req, t_dcache_hit, t_err;
    logic [15:0] t_ms_addr, t_ms_wdata, t_rdata;
    logic [1:0]  t_req_count, t_hit_count;

    logic [8:0]  act_flags;
    logic [8:0]  t_flags;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs[$];

    dmem_stage_ctrl dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wr(ex_wr),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .halt(halt),
        .ms_done(ms_done), .ms_hit(ms_hit), .ms_err(ms_err), .ms_rdata(ms_rdata),
        .ms_rd(ms_rd), .ms_wr(ms_wr), .ms_addr(ms_addr), .ms_wdata(ms_wdata),
        .stall(stall), .rdata(rdata), .resp_valid(resp_valid),
        .mem_read_done(mem_read_done), .mem_write_done(mem_write_done),
        .dcache_req(dcache_req), .dcache_hit(dcache_hit), .err(err),
        .req_count(req_count), .hit_count(hit_count)
    );

    dmem_stage_ctrl #(.TIMEOUT(4), .CNT_W(2)) dut_to (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wr(ex_wr),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .halt(halt),
        .ms_done(ms_done), .ms_hit(ms_hit), .ms_err(ms_err), .ms_rdata(ms_rdata),
        .ms_rd(t_ms_rd), .ms_wr(t_ms_wr), .ms_addr(t_ms_addr), .ms_wdata(t_ms_wdata),
        .stall(t_stall), .rdata(t_rdata), .resp_valid(t_resp_valid),
        .mem_read_done(t_mem_read_done), .mem_write_done(t_mem_write_done),
        .dcache_req(t_dcache_req), .dcache_hit(t_dcache_hit), .err(t_err),
        .req_count(t_req_count), .hit_count(t_hit_count)
    );

    assign act_flags = {ms_rd, ms_wr, stall, dcache_req, dcache_hit,
                        resp_valid, err, mem_read_done, mem_write_done};
    assign t_flags   = {t_ms_rd, t_ms_wr, t_stall, t_dcache_req, t_dcache_hit,
                        t_resp_valid, t_err, t_mem_read_done, t_mem_write_done};

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Watchdog so a broken design can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic [6:0] ctl, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic [15:0] msrd,
                                input logic [8:0] flags, input logic [15:0] e_addr,
                                input logic [15:0] e_wdata, input logic [15:0] e_rdata,
                                input logic [15:0] e_req, input logic [15:0] e_hit);
        vec_t v;
        v.ctl = ctl; v.addr = addr; v.wdata = wdata; v.msrd = msrd; v.flags = flags;
        v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_rdata = e_rdata;
        v.e_req = e_req; v.e_hit = e_hit;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%04h, wanted 0x%04h", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        ex_valid = 1'b0; ex_rd = 1'b0; ex_wr = 1'b0; halt = 1'b0;
        ex_addr = 16'h0; ex_wdata = 16'h0;
        ms_done = 1'b0; ms_hit = 1'b0; ms_err = 1'b0; ms_rdata = 16'h0;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        ex_valid = v.ctl[6]; ex_rd = v.ctl[5]; ex_wr = v.ctl[4]; halt = v.ctl[3];
        ms_done  = v.ctl[2]; ms_hit = v.ctl[1]; ms_err = v.ctl[0];
        ex_addr  = v.addr; ex_wdata = v.wdata; ms_rdata = v.msrd;
    endtask

    task automatic compareVector(input int i, input vec_t v);
        checkOutput($sformatf("v%0d flags", i), 16'(act_flags), 16'(v.flags));
        checkOutput($sformatf("v%0d ms_addr", i), ms_addr, v.e_addr);
        checkOutput($sformatf("v%0d ms_wdata", i), ms_wdata, v.e_wdata);
        checkOutput($sformatf("v%0d rdata", i), rdata, v.e_rdata);
        checkOutput($sformatf("v%0d req_count", i), req_count, v.e_req);
        checkOutput($sformatf("v%0d hit_count", i), hit_count, v.e_hit);
    endtask

    // One cycle of inputs for the hand-written sequences; returns at the sample point.
    task automatic cyc(input logic [6:0] ctl, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [15:0] msrd);
        applyStimulus(mk(ctl, addr, wdata, msrd, 9'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0));
        @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        clearInputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clearInputs();

        // Main-instance vectors: each row is one cycle with a hand-derived expectation.
        vecs.push_back(mk(7'h0, 16'h0000, 16'h0000, 16'h0000, 9'h0, 16'h0000, 16'h0000, 16'h0000, 0, 0));
        // load hit at 0x0010
        vecs.push_back(mk(I_V|I_RD, 16'h0010, 16'h0000, 16'h0000, F_RD|F_ST|F_REQ, 16'h0010, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk(I_V|I_RD|I_DONE|I_HIT, 16'h0010, 16'h0000, 16'hBEEF, F_ST|F_HIT, 16'h0010, 16'h0000, 16'h0000, 1, 0));
        vecs.push_back(mk(I_V|I_RD, 16'h0010, 16'h0000, 16'h0000, F_RV|F_MRD, 16'h0010, 16'h0000, 16'hBEEF, 1, 1));
        // store miss at 0x0100, done after five wait cycles
        vecs.push_back(mk(I_V|I_WR, 16'h0100, 16'h1234, 16'h0000, F_WR|F_ST|F_REQ, 16'h0100, 16'h1234, 16'hBEEF, 1, 1));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(I_V|I_WR, 16'h0100, 16'h1234, 16'h0000, F_ST, 16'h0100, 16'h1234, 16'hBEEF, 2, 1));
        vecs.push_back(mk(I_V|I_WR|I_DONE, 16'h0100, 16'h1234, 16'hDEAD, F_ST, 16'h0100, 16'h1234, 16'hBEEF, 2, 1));
        vecs.push_back(mk(I_V|I_WR, 16'h0100, 16'h1234, 16'h0000, F_RV|F_MWD, 16'h0100, 16'h1234, 16'hBEEF, 2, 1));
        // illegal op, then a spurious done in RESP and in IDLE
        vecs.push_back(mk(I_V|I_RD|I_WR, 16'h0200, 16'h0000, 16'h0000, F_ST, 16'h0100, 16'h1234, 16'hBEEF, 2, 1));
        vecs.push_back(mk(I_V|I_RD|I_WR|I_DONE|I_HIT, 16'h0200, 16'h0000, 16'h7777, F_RV|F_ERR, 16'h0100, 16'h1234, 16'hBEEF, 2, 1));
        vecs.push_back(mk(I_DONE|I_HIT, 16'h0000, 16'h0000, 16'h5555, 9'h0, 16'h0100, 16'h1234, 16'hBEEF, 2, 1));
        // halt blocks a new issue
        vecs.push_back(mk(I_V|I_RD|I_HALT, 16'h0300, 16'h0000, 16'h0000, 9'h0, 16'h0100, 16'h1234, 16'hBEEF, 2, 1));
        // back-to-back hit loads; halt raised during WAIT/RESP of the first
        vecs.push_back(mk(I_V|I_RD, 16'h0020, 16'h0000, 16'h0000, F_RD|F_ST|F_REQ, 16'h0020, 16'h0000, 16'hBEEF, 2, 1));
        vecs.push_back(mk(I_V|I_RD|I_HALT|I_DONE|I_HIT, 16'h0020, 16'h0000, 16'h1111, F_ST|F_HIT, 16'h0020, 16'h0000, 16'hBEEF, 3, 1));
        vecs.push_back(mk(I_V|I_RD|I_HALT, 16'h0020, 16'h0000, 16'h0000, F_RV|F_MRD, 16'h0020, 16'h0000, 16'h1111, 3, 2));
        vecs.push_back(mk(I_V|I_RD, 16'h0022, 16'h0000, 16'h0000, F_RD|F_ST|F_REQ, 16'h0022, 16'h0000, 16'h1111, 3, 2));
        vecs.push_back(mk(I_V|I_RD|I_DONE|I_HIT, 16'h0022, 16'h0000, 16'h2222, F_ST|F_HIT, 16'h0022, 16'h0000, 16'h1111, 4, 2));
        vecs.push_back(mk(I_V|I_RD, 16'h0022, 16'h0000, 16'h0000, F_RV|F_MRD, 16'h0022, 16'h0000, 16'h2222, 4, 3));
        // load completing with ms_err: data still captured, no read_done
        vecs.push_back(mk(I_V|I_RD, 16'h0030, 16'h0000, 16'h0000, F_RD|F_ST|F_REQ, 16'h0030, 16'h0000, 16'h2222, 4, 3));
        vecs.push_back(mk(I_V|I_RD|I_DONE|I_ERR, 16'h0030, 16'h0000, 16'h3333, F_ST, 16'h0030, 16'h0000, 16'h2222, 5, 3));
        vecs.push_back(mk(I_V|I_RD, 16'h0030, 16'h0000, 16'h0000, F_RV|F_ERR, 16'h0030, 16'h0000, 16'h3333, 5, 3));
        vecs.push_back(mk(7'h0, 16'h0000, 16'h0000, 16'h0000, 9'h0, 16'h0030, 16'h0000, 16'h3333, 5, 3));

        repeat (2) @(negedge clk);
        checkOutput("reset flags", 16'(act_flags), 16'h0);
        checkOutput("reset ms_addr", ms_addr, 16'h0);
        checkOutput("reset ms_wdata", ms_wdata, 16'h0);
        checkOutput("reset rdata", rdata, 16'h0);
        checkOutput("reset req_count", req_count, 16'h0);
        checkOutput("reset hit_count", hit_count, 16'h0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            compareVector(i, vecs[i]);
        end

        // Timeout on the TIMEOUT=4 instance, after a hit load sets rdata.
        doReset();
        cyc(I_V|I_RD, 16'h0040, 16'h0, 16'h0);
        checkOutput("to issue flags", 16'(t_flags), 16'(F_RD|F_ST|F_REQ));
        cyc(I_V|I_RD|I_DONE|I_HIT, 16'h0040, 16'h0, 16'hA5A5);
        checkOutput("to done flags", 16'(t_flags), 16'(F_ST|F_HIT));
        cyc(I_V|I_RD, 16'h0040, 16'h0, 16'h0);
        checkOutput("to resp flags", 16'(t_flags), 16'(F_RV|F_MRD));
        checkOutput("to resp rdata", t_rdata, 16'hA5A5);
        cyc(I_V|I_RD, 16'h0042, 16'h0, 16'h0);
        checkOutput("to2 issue flags", 16'(t_flags), 16'(F_RD|F_ST|F_REQ));
        for (int k = 1; k <= 4; k++) begin
            cyc(I_V|I_RD, 16'h0042, 16'h0, 16'h0);
            checkOutput($sformatf("to2 wait%0d flags", k), 16'(t_flags), 16'(F_ST));
        end
        cyc(I_V|I_RD, 16'h0042, 16'h0, 16'h0);
        checkOutput("to2 timeout flags", 16'(t_flags), 16'(F_RV|F_ERR));
        checkOutput("to2 timeout rdata", t_rdata, 16'hA5A5);
        checkOutput("to2 req_count", 16'(t_req_count), 16'd2);
        checkOutput("to2 hit_count", 16'(t_hit_count), 16'd1);
        cyc(7'h0, 16'h0, 16'h0, 16'h0);
        checkOutput("to2 idle flags", 16'(t_flags), 16'h0);

        // Counter saturation on the 2-bit counters: three more hit loads.
        for (int k = 0; k < 3; k++) begin
            cyc(I_V|I_RD, 16'h0050 + 16'(k), 16'h0, 16'h0);
            cyc(I_V|I_RD|I_DONE|I_HIT, 16'h0050 + 16'(k), 16'h0, 16'h6000 + 16'(k));
            cyc(I_V|I_RD, 16'h0050 + 16'(k), 16'h0, 16'h0);
            checkOutput($sformatf("sat%0d flags", k), 16'(t_flags), 16'(F_RV|F_MRD));
            checkOutput($sformatf("sat%0d req_count", k), 16'(t_req_count), 16'd3);
            checkOutput($sformatf("sat%0d hit_count", k), 16'(t_hit_count), (k == 0) ? 16'd2 : 16'd3);
            cyc(7'h0, 16'h0, 16'h0, 16'h0);
        end

        // Reset while the main instance waits on a store; a late done is ignored.
        doReset();
        cyc(I_V|I_WR, 16'h0500, 16'h9999, 16'h0);
        checkOutput("rw issue flags", 16'(act_flags), 16'(F_WR|F_ST|F_REQ));
        checkOutput("rw issue ms_addr", ms_addr, 16'h0500);
        cyc(I_V|I_WR, 16'h0500, 16'h9999, 16'h0);
        checkOutput("rw wait flags", 16'(act_flags), 16'(F_ST));
        checkOutput("rw wait req_count", req_count, 16'd1);
        #1;
        rst = 1'b1;
        clearInputs();
        #1;
        checkOutput("rw reset flags", 16'(act_flags), 16'h0);
        checkOutput("rw reset req_count", req_count, 16'h0);
        checkOutput("rw reset ms_addr", ms_addr, 16'h0);
        checkOutput("rw reset ms_wdata", ms_wdata, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc(I_DONE|I_HIT, 16'h0, 16'h0, 16'h4444);
        checkOutput("rw late done flags", 16'(act_flags), 16'h0);
        cyc(7'h0, 16'h0, 16'h0, 16'h0);
        checkOutput("rw after flags", 16'(act_flags), 16'h0);
        checkOutput("rw after hit_count", hit_count, 16'h0);
        checkOutput("rw after rdata", rdata, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
